// File: rtl/mario_pkg.sv
// Shared constants and types for the on-screen block array and its level feeder.
package mario_pkg;

  localparam int BLOCK_ID_W = 3;
  localparam int ARRAY_ROWS = 10;
  localparam int ARRAY_COLS = 10;
  localparam int COL_W      = BLOCK_ID_W * ARRAY_ROWS;
  localparam int BLOCK_PX   = 40;

  typedef enum logic [BLOCK_ID_W-1:0] {
    EMPTY    = 3'b000,
    BRICK    = 3'b001,
    QUESTION = 3'b011
  } block_id_t;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    PUSH,
    READY,
    DONE
  } feeder_state_t;

  // Block id of row r (row 0 at the top) within a column word.
  function automatic block_id_t block_at(input logic [COL_W-1:0] col, input int row);
    return block_id_t'(col[row*BLOCK_ID_W +: BLOCK_ID_W]);
  endfunction

endpackage

// File: rtl/level_column_feeder.sv
// Streams level columns from the ROM into the block array: 10-column fill after reset,
// then one Shift per camera scroll. One column is always kept prefetched.
module level_column_feeder
  import mario_pkg::*;
#(
  parameter int LEVEL_COLS = 64,
  parameter int ADDR_W     = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              scroll_req,
  input  logic [COL_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              Shift,
  output logic [COL_W-1:0]  new_block_id,
  output logic              busy,
  output logic              level_end,
  output logic              overrun
);

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(LEVEL_COLS);
  localparam logic [3:0]      FILL_N   = 4'(ARRAY_COLS);

  feeder_state_t    state;
  logic [ADDR_W:0]  col_ptr;
  logic [3:0]       fill_cnt;
  logic             pending;
  logic [COL_W-1:0] col_buf;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= FETCH;
      col_ptr      <= '0;
      fill_cnt     <= '0;
      pending      <= 1'b0;
      col_buf      <= '0;
      rom_addr     <= '0;
      Shift        <= 1'b0;
      new_block_id <= '0;
      busy         <= 1'b1;
      level_end    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      Shift <= 1'b0;

      // Only one request can wait while a fetch is in progress; a second one is lost.
      if (scroll_req && (state == FETCH || state == WAIT || state == PUSH)) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        FETCH: begin
          rom_addr <= col_ptr[ADDR_W-1:0];
          state    <= WAIT;
          busy     <= 1'b1;
        end
        WAIT: begin
          col_buf <= rom_data;
          col_ptr <= col_ptr + 1'b1;
          if (fill_cnt < FILL_N) begin
            state <= PUSH;
          end else begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        PUSH: begin
          Shift        <= 1'b1;
          new_block_id <= col_buf;
          fill_cnt     <= fill_cnt + 1'b1;
          state        <= FETCH;
        end
        READY: begin
          if (scroll_req || pending) begin
            Shift        <= 1'b1;
            new_block_id <= col_buf;
            // A fresh request arriving together with a serviced pending one stays queued.
            pending      <= scroll_req && pending;
            if (col_ptr == LAST_PTR) begin
              state     <= DONE;
              level_end <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
        end
        DONE: begin
          level_end <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state <= FETCH;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
